// File: rtl/float_entry_pkg.sv
// Shared widths, FSM states, command encoding and command priority for float_operand_entry.
package float_entry_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  // Exponent field position inside an operand word.
  localparam int unsigned ExpLsb = MAN_W;
  localparam int unsigned ExpMsb = MAN_W + EXP_W - 1;
  localparam int unsigned ShW    = $clog2(W);

  localparam logic [EXP_W-1:0] BiasE   = EXP_W'(BIAS);
  // Largest window offset that still fits a full nibble in the mantissa.
  localparam logic [EXP_W-1:0] WinMaxE = EXP_W'(MAN_W - 4);

  // Button indices in the pending-flag vector.
  localparam int unsigned IdxClear     = 0;
  localparam int unsigned IdxExpOne    = 1;
  localparam int unsigned IdxExpInc    = 2;
  localparam int unsigned IdxExpDec    = 3;
  localparam int unsigned IdxCursorRst = 4;
  localparam int unsigned NumBtn       = 5;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } entry_state_t;

  typedef enum logic [2:0] {
    CmdNone,
    CmdClear,
    CmdExpOne,
    CmdExpInc,
    CmdExpDec,
    CmdCursorRst,
    CmdKey
  } entry_cmd_t;

  // Priority: CLEAR > EXP_ONE > EXP_INC > EXP_DEC > CURSOR_RST > key.
  function automatic entry_cmd_t pick_cmd(input logic [NumBtn-1:0] pend, input logic key_pend);
    entry_cmd_t cmd;
    cmd = CmdNone;
    if (pend[IdxClear])          cmd = CmdClear;
    else if (pend[IdxExpOne])    cmd = CmdExpOne;
    else if (pend[IdxExpInc])    cmd = CmdExpInc;
    else if (pend[IdxExpDec])    cmd = CmdExpDec;
    else if (pend[IdxCursorRst]) cmd = CmdCursorRst;
    else if (key_pend)           cmd = CmdKey;
    return cmd;
  endfunction

endpackage

// File: rtl/float_operand_entry_btn_edge_sync.sv
// Two-flop synchronizer with rising-edge detector for one asynchronous button or switch.
module btn_edge_sync #(
  // Buttons reset to 1 so a button held through reset yields no edge until re-pressed.
  parameter logic RstVal = 1'b0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q   <= RstVal;
      s2_q   <= RstVal;
      prev_q <= RstVal;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/float_operand_entry.sv
// Operand-entry stage: turns keypad nibbles and button commands into float32 operands A and B.
module float_operand_entry
  import float_entry_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         KEY_VALID,
  input  logic [3:0]   KEY_VAL,
  input  logic         MODE,
  input  logic         SEL_ROW,
  input  logic         BTN_EXP_INC,
  input  logic         BTN_EXP_DEC,
  input  logic         BTN_EXP_ONE,
  input  logic         BTN_CLEAR,
  input  logic         BTN_CURSOR_RST,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [2:0]   CURSOR,
  output logic         UPDATED,
  output logic         REJECT,
  output logic         DROP,
  output logic         BUSY
);

  logic [NumBtn-1:0] btn_raw, btn_rise, btn_lvl;
  logic              mode_lvl, sel_lvl;
  logic              mode_rise, sel_rise;

  assign btn_raw[IdxClear]     = BTN_CLEAR;
  assign btn_raw[IdxExpOne]    = BTN_EXP_ONE;
  assign btn_raw[IdxExpInc]    = BTN_EXP_INC;
  assign btn_raw[IdxExpDec]    = BTN_EXP_DEC;
  assign btn_raw[IdxCursorRst] = BTN_CURSOR_RST;

  for (genvar i = 0; i < NumBtn; i++) begin : g_btn
    btn_edge_sync #(.RstVal(1'b1)) u_sync (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .d_i     (btn_raw[i]),
      .level_o (btn_lvl[i]),
      .rise_o  (btn_rise[i])
    );
  end

  btn_edge_sync #(.RstVal(1'b0)) u_mode_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .d_i     (MODE),
    .level_o (mode_lvl),
    .rise_o  (mode_rise)
  );

  btn_edge_sync #(.RstVal(1'b0)) u_sel_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .d_i     (SEL_ROW),
    .level_o (sel_lvl),
    .rise_o  (sel_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{btn_lvl, mode_rise, sel_rise};

  entry_state_t      state_q, state_d;
  entry_cmd_t        cmd_q, cmd_d, cmd_sel;
  logic              sel_q, sel_d, mode_q, mode_d;
  logic [3:0]        kval_q, kval_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [2:0]        cursor_q, cursor_d;
  logic              updated_q, updated_d, reject_q, reject_d, drop_q, drop_d;
  logic [NumBtn-1:0] pend_q, pend_d, take_btn;
  logic              key_pend_q, key_pend_d, take_key, key_full;
  logic [3:0]        key_val_q, key_val_d;
  logic              sel_prev_q;

  logic [W-1:0]      op, op_new;
  logic [EXP_W-1:0]  e, s;
  logic [ShW-1:0]    sh;
  logic              rej;

  assign cmd_sel = pick_cmd(pend_q, key_pend_q);

  // Sticky button events and the single pending-key slot.
  always_comb begin
    pend_d     = btn_rise | (pend_q & ~take_btn);
    key_full   = key_pend_q & ~take_key;
    key_pend_d = key_full;
    key_val_d  = key_val_q;
    drop_d     = 1'b0;
    if (KEY_VALID) begin
      if (key_full) begin
        drop_d = 1'b1;
      end else begin
        key_pend_d = 1'b1;
        key_val_d  = KEY_VAL;
      end
    end
  end

  // FSM next state, operand writes and cursor update.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    kval_d    = kval_q;
    a_d       = a_q;
    b_d       = b_q;
    cursor_d  = cursor_q;
    updated_d = 1'b0;
    reject_d  = 1'b0;
    take_btn  = '0;
    take_key  = 1'b0;
    op        = sel_q ? b_q : a_q;
    op_new    = op;
    e         = op[ExpMsb:ExpLsb];
    s         = e - BiasE;
    sh        = '0;
    rej       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_sel != CmdNone) begin
          cmd_d   = cmd_sel;
          sel_d   = sel_lvl;
          mode_d  = mode_lvl;
          kval_d  = key_val_q;
          state_d = StApply;
          case (cmd_sel)
            CmdClear:     take_btn[IdxClear]     = 1'b1;
            CmdExpOne:    take_btn[IdxExpOne]    = 1'b1;
            CmdExpInc:    take_btn[IdxExpInc]    = 1'b1;
            CmdExpDec:    take_btn[IdxExpDec]    = 1'b1;
            CmdCursorRst: take_btn[IdxCursorRst] = 1'b1;
            CmdKey:       take_key               = 1'b1;
            default: ;
          endcase
        end
      end
      StApply: begin
        case (cmd_q)
          CmdClear: begin
            op_new   = '0;
            cursor_d = '0;
          end
          CmdExpOne:    op_new[ExpMsb:ExpLsb] = BiasE;
          CmdExpInc:    op_new[ExpMsb:ExpLsb] = e + EXP_W'(1);
          CmdExpDec:    op_new[ExpMsb:ExpLsb] = e - EXP_W'(1);
          CmdCursorRst: cursor_d = '0;
          CmdKey: begin
            if (mode_q) begin
              // Cursor 0 addresses bits 31:28, so the nibble LSB sits at 4*(7-c).
              sh       = {~cursor_q, 2'b00};
              op_new   = (op & ~(W'(4'hF) << sh)) | (W'(kval_q) << sh);
              cursor_d = cursor_q + 3'd1;
            end else if ((e < BiasE) || (s > WinMaxE)) begin
              rej = 1'b1;
            end else begin
              sh     = ShW'(WinMaxE - s);
              op_new = (op & ~(W'(4'hF) << sh)) | (W'(kval_q) << sh);
            end
          end
          default: ;
        endcase
        if (sel_q) b_d = op_new;
        else       a_d = op_new;
        updated_d = ~rej;
        reject_d  = rej;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Switching rows restarts raw entry at the top nibble.
    if (sel_lvl != sel_prev_q) cursor_d = '0;
  end

  // State, operand and pulse registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      cmd_q      <= CmdNone;
      sel_q      <= 1'b0;
      mode_q     <= 1'b0;
      kval_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cursor_q   <= '0;
      updated_q  <= 1'b0;
      reject_q   <= 1'b0;
      drop_q     <= 1'b0;
      pend_q     <= '0;
      key_pend_q <= 1'b0;
      key_val_q  <= '0;
      sel_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      kval_q     <= kval_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cursor_q   <= cursor_d;
      updated_q  <= updated_d;
      reject_q   <= reject_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
      key_pend_q <= key_pend_d;
      key_val_q  <= key_val_d;
      sel_prev_q <= sel_lvl;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign CURSOR  = cursor_q;
  assign UPDATED = updated_q;
  assign REJECT  = reject_q;
  assign DROP    = drop_q;
  assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_float_operand_entry.sv
// Scoreboard bench for float_operand_entry: directed stimulus pushes expectations, monitor checks.
module tb_float_operand_entry;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_VAL = 4'h0;
  logic        MODE = 1'b0, SEL_ROW = 1'b0;
  logic        BTN_EXP_INC = 1'b0, BTN_EXP_DEC = 1'b0, BTN_EXP_ONE = 1'b0;
  logic        BTN_CLEAR = 1'b0, BTN_CURSOR_RST = 1'b0;
  logic [31:0] A, B;
  logic [2:0]  CURSOR;
  logic        UPDATED, REJECT, DROP, BUSY;

  float_operand_entry dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .KEY_VALID      (KEY_VALID),
    .KEY_VAL        (KEY_VAL),
    .MODE           (MODE),
    .SEL_ROW        (SEL_ROW),
    .BTN_EXP_INC    (BTN_EXP_INC),
    .BTN_EXP_DEC    (BTN_EXP_DEC),
    .BTN_EXP_ONE    (BTN_EXP_ONE),
    .BTN_CLEAR      (BTN_CLEAR),
    .BTN_CURSOR_RST (BTN_CURSOR_RST),
    .A              (A),
    .B              (B),
    .CURSOR         (CURSOR),
    .UPDATED        (UPDATED),
    .REJECT         (REJECT),
    .DROP           (DROP),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cur;
  } exp_t;

  exp_t upd_q[$];
  exp_t rej_q[$];
  exp_t m_e;
  int   drop_exp = 0;
  int   total = 0;
  int   bad = 0;

  localparam int BClear = 0, BOne = 1, BInc = 2, BDec = 3, BCrst = 4;

  logic [3:0]  raw_k[8] = '{4'h4, 4'h0, 4'h4, 4'h9, 4'h0, 4'hF, 4'hD, 4'hB};
  logic [31:0] raw_a[8] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40490000,
                            32'h40490000, 32'h40490F00, 32'h40490FD0, 32'h40490FDB};
  logic [31:0] fill_a[8] = '{32'hF2490FDB, 32'hFF490FDB, 32'hFFF90FDB, 32'hFFFF0FDB,
                             32'hFFFFFFDB, 32'hFFFFFFDB, 32'hFFFFFFFB, 32'hFFFFFFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (UPDATED) begin
      check("upd_expected", 32'(upd_q.size() != 0), 32'd1);
      if (upd_q.size() != 0) begin
        m_e = upd_q.pop_front();
        check("upd_A", A, m_e.a);
        check("upd_B", B, m_e.b);
        check("upd_CURSOR", 32'(CURSOR), 32'(m_e.cur));
      end
    end
    if (REJECT) begin
      check("rej_expected", 32'(rej_q.size() != 0), 32'd1);
      if (rej_q.size() != 0) begin
        m_e = rej_q.pop_front();
        check("rej_A", A, m_e.a);
        check("rej_B", B, m_e.b);
        check("rej_CURSOR", 32'(CURSOR), 32'(m_e.cur));
      end
    end
    if (DROP) begin
      check("drop_expected", 32'(drop_exp > 0), 32'd1);
      if (drop_exp > 0) drop_exp--;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_upd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    exp_t t;
    t = '{a: a, b: b, cur: c};
    upd_q.push_back(t);
  endtask

  task automatic push_rej(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    exp_t t;
    t = '{a: a, b: b, cur: c};
    rej_q.push_back(t);
  endtask

  task automatic key(input logic [3:0] v);
    KEY_VALID = 1'b1;
    KEY_VAL   = v;
    tick(1);
    KEY_VALID = 1'b0;
    tick(4);
  endtask

  task automatic set_btn(input int id, input logic v);
    case (id)
      BClear:  BTN_CLEAR      = v;
      BOne:    BTN_EXP_ONE    = v;
      BInc:    BTN_EXP_INC    = v;
      BDec:    BTN_EXP_DEC    = v;
      default: BTN_CURSOR_RST = v;
    endcase
  endtask

  task automatic btn(input int id);
    set_btn(id, 1'b1);
    tick(5);
    set_btn(id, 1'b0);
    tick(5);
  endtask

  task automatic drain();
    int n = 0;
    while ((upd_q.size() != 0 || rej_q.size() != 0 || drop_exp != 0 || BUSY) && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d cycles expected <200", n);
    end
    tick(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got t=%0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    // Reset state
    tick(3);
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_CURSOR", 32'(CURSOR), 32'd0);
    check("rst_UPDATED", 32'(UPDATED), 32'd0);
    check("rst_REJECT", 32'(REJECT), 32'd0);
    check("rst_DROP", 32'(DROP), 32'd0);
    check("rst_BUSY", 32'(BUSY), 32'd0);
    RESET_N = 1'b1;
    tick(5);

    // Raw entry of pi into A, with latency measured on the first key
    MODE = 1'b1;
    SEL_ROW = 1'b0;
    tick(5);
    push_upd(raw_a[0], 32'h0, 3'd1);
    KEY_VALID = 1'b1;
    KEY_VAL = raw_k[0];
    tick(1);
    KEY_VALID = 1'b0;
    lat = 1;
    while (!UPDATED && lat < 10) begin
      tick(1);
      lat++;
    end
    check("key_latency", 32'(lat), 32'd3);
    tick(4);
    for (int i = 1; i < 8; i++) begin
      push_upd(raw_a[i], 32'h0, 3'(i + 1));
      key(raw_k[i]);
    end
    drain();
    check("raw_A", A, 32'h40490FDB);
    check("raw_B", B, 32'h0);
    check("raw_CURSOR", 32'(CURSOR), 32'd0);

    // Window entry into B
    SEL_ROW = 1'b1;
    MODE = 1'b0;
    tick(5);
    push_upd(32'h40490FDB, 32'h3F800000, 3'd0);
    btn(BOne);
    push_upd(32'h40490FDB, 32'h3FE00000, 3'd0);
    key(4'hC);
    push_upd(32'h40490FDB, 32'h40600000, 3'd0);
    btn(BInc);
    push_upd(32'h40490FDB, 32'h40E00000, 3'd0);
    btn(BInc);
    push_upd(32'h40490FDB, 32'h40FE0000, 3'd0);
    key(4'hF);
    drain();
    check("win_B", B, 32'h40FE0000);

    // Reject below range (e=126)
    push_upd(32'h40490FDB, 32'h3FFE0000, 3'd0);
    btn(BOne);
    push_upd(32'h40490FDB, 32'h3F7E0000, 3'd0);
    btn(BDec);
    push_rej(32'h40490FDB, 32'h3F7E0000, 3'd0);
    key(4'h5);
    drain();
    check("rej_lo_B", B, 32'h3F7E0000);

    // Build e=147 in B by raw entry, reject, then accept at e=146 (lowest nibble)
    push_upd(32'h40490FDB, 32'h0, 3'd0);
    btn(BClear);
    MODE = 1'b1;
    tick(5);
    push_upd(32'h40490FDB, 32'h40000000, 3'd1);
    key(4'h4);
    push_upd(32'h40490FDB, 32'h49000000, 3'd2);
    key(4'h9);
    push_upd(32'h40490FDB, 32'h49800000, 3'd3);
    key(4'h8);
    MODE = 1'b0;
    tick(5);
    push_rej(32'h40490FDB, 32'h49800000, 3'd3);
    key(4'h5);
    push_upd(32'h40490FDB, 32'h49000000, 3'd3);
    btn(BDec);
    push_upd(32'h40490FDB, 32'h49000005, 3'd3);
    key(4'h5);
    drain();
    check("win_edge_B", B, 32'h49000005);

    // Exponent wrap with sign set
    push_upd(32'h40490FDB, 32'h0, 3'd0);
    btn(BClear);
    MODE = 1'b1;
    tick(5);
    push_upd(32'h40490FDB, 32'hF0000000, 3'd1);
    key(4'hF);
    push_upd(32'h40490FDB, 32'hFF000000, 3'd2);
    key(4'hF);
    push_upd(32'h40490FDB, 32'hFF800000, 3'd3);
    key(4'h8);
    MODE = 1'b0;
    tick(5);
    push_upd(32'h40490FDB, 32'h80000000, 3'd3);
    btn(BInc);
    push_upd(32'h40490FDB, 32'hFF800000, 3'd3);
    btn(BDec);
    drain();
    check("wrap_B", B, 32'hFF800000);

    // Row change zeroes cursor; three back-to-back keys: two written, one dropped
    SEL_ROW = 1'b0;
    MODE = 1'b1;
    tick(5);
    check("selchg_CURSOR", 32'(CURSOR), 32'd0);
    push_upd(32'h10490FDB, 32'hFF800000, 3'd1);
    push_upd(32'h12490FDB, 32'hFF800000, 3'd2);
    drop_exp++;
    KEY_VALID = 1'b1;
    KEY_VAL = 4'h1;
    tick(1);
    KEY_VAL = 4'h2;
    tick(1);
    KEY_VAL = 4'h3;
    tick(1);
    KEY_VALID = 1'b0;
    drain();
    check("buf_A", A, 32'h12490FDB);
    check("buf_CURSOR", 32'(CURSOR), 32'd2);

    // Cursor reset, then fill A with ones
    push_upd(32'h12490FDB, 32'hFF800000, 3'd0);
    btn(BCrst);
    for (int i = 0; i < 8; i++) begin
      push_upd(fill_a[i], 32'hFF800000, 3'(i + 1));
      key(4'hF);
    end
    drain();
    check("fill_A", A, 32'hFFFFFFFF);

    // CLEAR and key become pending in the same cycle: CLEAR wins
    push_upd(32'h0, 32'hFF800000, 3'd0);
    push_upd(32'h70000000, 32'hFF800000, 3'd1);
    BTN_CLEAR = 1'b1;
    tick(2);
    KEY_VALID = 1'b1;
    KEY_VAL = 4'h7;
    tick(1);
    KEY_VALID = 1'b0;
    tick(3);
    BTN_CLEAR = 1'b0;
    tick(5);
    drain();
    check("prio_A", A, 32'h70000000);

    // Asynchronous reset during APPLY, with a button held through reset
    KEY_VALID = 1'b1;
    KEY_VAL = 4'h3;
    tick(1);
    KEY_VALID = 1'b0;
    tick(1);
    check("apply_BUSY", 32'(BUSY), 32'd1);
    #2;
    RESET_N = 1'b0;
    BTN_EXP_INC = 1'b1;
    #1;
    check("arst_A", A, 32'h0);
    check("arst_B", B, 32'h0);
    check("arst_CURSOR", 32'(CURSOR), 32'd0);
    check("arst_UPDATED", 32'(UPDATED), 32'd0);
    check("arst_REJECT", 32'(REJECT), 32'd0);
    check("arst_DROP", 32'(DROP), 32'd0);
    check("arst_BUSY", 32'(BUSY), 32'd0);
    tick(3);
    RESET_N = 1'b1;
    tick(20);
    check("post_rst_A", A, 32'h0);
    check("post_rst_BUSY", 32'(BUSY), 32'd0);
    BTN_EXP_INC = 1'b0;
    tick(5);
    push_upd(32'h00800000, 32'h0, 3'd0);
    btn(BInc);
    drain();
    check("repress_A", A, 32'h00800000);

    check("left_upd", 32'(upd_q.size()), 32'd0);
    check("left_rej", 32'(rej_q.size()), 32'd0);
    check("left_drop", 32'(drop_exp), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
